// File: rtl/axo_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axo_bus_pkg
//  Description : Shared encodings and helpers for the Axolotl32 data-memory
//                bus: access-size codes, responder states, byte-lane masks
//                and data alignment functions.
//  Revision    : 1.0  initial release
// ============================================================================
package axo_bus_pkg;

   localparam logic [1:0] AS_BYTE = 2'd0;
   localparam logic [1:0] AS_HALF = 2'd1;
   localparam logic [1:0] AS_WORD = 2'd2;
   localparam logic [1:0] AS_BAD  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } resp_state_t;

   // Byte enables of an access of the given size starting at byte lane lo.
   function automatic logic [3:0] lane_mask(input logic [1:0] asize, input logic [1:0] lo);
      logic [3:0] base_m;
      case (asize)
         AS_BYTE: base_m = 4'b0001;
         AS_HALF: base_m = 4'b0011;
         AS_WORD: base_m = 4'b1111;
         default: base_m = 4'b0000;
      endcase
      return base_m << lo;
   endfunction

   // True when the low address bits break natural alignment for the size.
   function automatic logic misaligned(input logic [1:0] asize, input logic [1:0] lo);
      case (asize)
         AS_HALF: return lo[0];
         AS_WORD: return (lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // Right-align the addressed bytes of a RAM word and zero-extend them.
   function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] asize,
                                              input logic [1:0] lo);
      logic [31:0] shifted;
      shifted = word >> {lo, 3'b000};
      case (asize)
         AS_BYTE: return {24'h0, shifted[7:0]};
         AS_HALF: return {16'h0, shifted[15:0]};
         AS_WORD: return shifted;
         default: return 32'h0;
      endcase
   endfunction

   // Move right-aligned write data onto the byte lanes it will occupy.
   function automatic logic [31:0] write_align(input logic [31:0] data, input logic [1:0] lo);
      return data << {lo, 3'b000};
   endfunction

endpackage : axo_bus_pkg
`default_nettype wire

// File: rtl/axo_ram_be.sv
`default_nettype none
// ============================================================================
//  Module      : axo_ram_be
//  Description : Word-organised RAM with per-byte write enables, synchronous
//                write and combinational read. Starts all zero.
//  Revision    : 1.0  initial release
// ============================================================================
module axo_ram_be #(
   parameter int    DEPTH_LOG2 = 10,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic [3:0]            be_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0] mem_q [DEPTH];

   // Power-up contents: all zero.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] = '0;
      end
   end

   // Commit only the enabled byte lanes of the addressed word.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule : axo_ram_be
`default_nettype wire

// File: rtl/axo_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axo_mem_responder
//  Description : Target end of the Axolotl32 data-memory bus. Accepts a
//                read or write, inserts WAIT_STATES idle cycles, completes
//                with a one-cycle mem_ready strobe, steers byte lanes and
//                reports erroneous accesses on fault / fault_addr.
//  Revision    : 1.0  initial release
// ============================================================================
module axo_mem_responder
   import axo_bus_pkg::*;
#(
   parameter logic [31:0] BASE        = 32'h0000_0000,
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_STATES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [1:0]  mem_asize,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   inout  wire  [31:0] mem_data,
   output logic        fault,
   output logic [31:0] fault_addr
);

   // Byte span of the RAM; one extra bit so the top of a large map cannot wrap.
   localparam logic [32:0] SPAN    = 33'd4 << DEPTH_LOG2;
   localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   resp_state_t state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic [1:0]  asize_q;
   logic        re_q;
   logic        we_q;
   logic        err_q;
   logic        ready_q;
   logic        fault_q;
   logic [31:0] fault_addr_q;
   logic        drive_q;

   logic [31:0] off_d;
   logic        in_range_d;
   logic        err_d;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] rd_data;
   logic [DEPTH_LOG2-1:0] ram_idx;

   // Classify the request presented on the bus this cycle.
   always_comb begin
      off_d      = mem_addr - BASE;
      in_range_d = (mem_addr >= BASE) && ({1'b0, off_d} < SPAN);
      err_d      = (mem_re & mem_we)
                 | (mem_asize == AS_BAD)
                 | misaligned(mem_asize, mem_addr[1:0])
                 | ~in_range_d;
   end

   // Responder sequencing: accept, count wait states, complete for one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         addr_q       <= 32'h0;
         asize_q      <= AS_BYTE;
         re_q         <= 1'b0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         ready_q      <= 1'b0;
         fault_q      <= 1'b0;
         fault_addr_q <= 32'h0;
         drive_q      <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         drive_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mem_re | mem_we) begin
                  addr_q  <= mem_addr;
                  asize_q <= mem_asize;
                  re_q    <= mem_re;
                  we_q    <= mem_we;
                  err_q   <= err_d;
                  if (WAIT_STATES == 0) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b1;
                     fault_q <= err_d;
                     drive_q <= mem_re & ~mem_we;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= WS_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_DONE;
                  ready_q <= 1'b1;
                  fault_q <= err_q;
                  drive_q <= re_q & ~we_q;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               if (err_q) begin
                  fault_addr_q <= addr_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // RAM port: lanes are written only on the DONE edge of a clean write.
   always_comb begin
      ram_idx   = DEPTH_LOG2'((addr_q - BASE) >> 2);
      ram_be    = (state_q == ST_DONE && we_q && !err_q) ? lane_mask(asize_q, addr_q[1:0]) : 4'b0000;
      ram_wdata = write_align(mem_data, addr_q[1:0]);
      rd_data   = err_q ? 32'h0 : read_align(ram_rdata, asize_q, addr_q[1:0]);
   end

   axo_ram_be #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .INIT_FILE  (INIT_FILE)
   ) u_ram (
      .clk     (clk),
      .be_i    (ram_be),
      .addr_i  (ram_idx),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // drive_q is cleared by reset, so the bus is released as soon as rst falls.
   assign mem_data   = drive_q ? rd_data : 32'hzzzz_zzzz;
   assign mem_ready  = ready_q;
   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;

endmodule : axo_mem_responder
`default_nettype wire

// File: tb/tb_axo_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axo_mem_responder
//  Description : Self-checking bench for axo_mem_responder. Two instances
//                (WAIT_STATES=0 and WAIT_STATES=1) are driven with directed
//                and random accesses and compared against a byte-array
//                model of the memory map.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axo_mem_responder;

   localparam logic [31:0] BASE       = 32'h0000_4000;
   localparam int          DEPTH_LOG2 = 10;
   localparam int          NBYTES     = 4 << DEPTH_LOG2;
   // A released bus floats high through the pull on the bus nets.
   localparam logic [31:0] Z_SEEN     = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        re_s   [2];
   logic        we_s   [2];
   logic [1:0]  as_s   [2];
   logic [31:0] addr_s [2];
   logic [31:0] drv_s  [2];
   logic        oe_s   [2];
   logic        ready_o[2];
   logic        fault_o[2];
   logic [31:0] faddr_o[2];

   tri1 [31:0] bus0;
   tri1 [31:0] bus1;
   assign bus0 = oe_s[0] ? drv_s[0] : 32'hzzzz_zzzz;
   assign bus1 = oe_s[1] ? drv_s[1] : 32'hzzzz_zzzz;

   axo_mem_responder #(.BASE(BASE), .DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
      .clk(clk), .rst(rst), .mem_re(re_s[0]), .mem_we(we_s[0]), .mem_asize(as_s[0]),
      .mem_ready(ready_o[0]), .mem_addr(addr_s[0]), .mem_data(bus0),
      .fault(fault_o[0]), .fault_addr(faddr_o[0]));

   axo_mem_responder #(.BASE(BASE), .DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(1), .INIT_FILE("")) u_ws1 (
      .clk(clk), .rst(rst), .mem_re(re_s[1]), .mem_we(we_s[1]), .mem_asize(as_s[1]),
      .mem_ready(ready_o[1]), .mem_addr(addr_s[1]), .mem_data(bus1),
      .fault(fault_o[1]), .fault_addr(faddr_o[1]));

   // Reference model: flat byte image of each instance plus last fault address.
   logic [7:0]  mdl [2][NBYTES];
   logic [31:0] exp_faddr [2];

   int checks   = 0;
   int failures = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bus_val(input int d);
      return (d == 0) ? bus0 : bus1;
   endfunction

   function automatic bit mdl_fault(input bit re, input bit we, input logic [1:0] sz,
                                    input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      if (re && we)                 return 1'b1;
      if (sz == 2'd3)               return 1'b1;
      if ((a % (32'd1 << sz)) != 0) return 1'b1;
      return (off < 0) || (off >= longint'(NBYTES));
   endfunction

   function automatic logic [31:0] mdl_read(input int d, input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] v;
      int          off;
      v   = 32'h0;
      off = int'(a - BASE);
      for (int i = 0; i < (1 << sz); i++) v[8*i +: 8] = mdl[d][off + i];
      return v;
   endfunction

   task automatic mdl_write(input int d, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] data);
      int off;
      off = int'(a - BASE);
      for (int i = 0; i < (1 << sz); i++) mdl[d][off + i] = data[8*i +: 8];
   endtask

   // One complete bus transaction with latency, data, fault and release checks.
   task automatic access(input int d, input bit re, input bit we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
      bit          f;
      bit          seen;
      bit          got_f;
      int          lat;
      logic [31:0] rd;
      f     = mdl_fault(re, we, sz, a);
      seen  = 1'b0;
      got_f = 1'b0;
      lat   = 0;
      rd    = 32'h0;
      @(posedge clk); #1;
      re_s[d] = re; we_s[d] = we; as_s[d] = sz; addr_s[d] = a; drv_s[d] = wd;
      oe_s[d] = we && !re;
      while (!seen && lat < 40) begin
         @(negedge clk);
         if (ready_o[d] === 1'b1) begin
            seen  = 1'b1;
            rd    = bus_val(d);
            got_f = fault_o[d];
         end else begin
            lat++;
            if (!oe_s[d]) chk_eq({tag, " bus before ready"}, bus_val(d), Z_SEEN);
         end
      end
      chk_eq({tag, " latency"}, 32'(lat), 32'(1 + d));
      chk_eq({tag, " fault"}, {31'h0, got_f}, {31'h0, f});
      if (re && !we) chk_eq({tag, " rdata"}, rd, f ? 32'h0 : mdl_read(d, a, sz));
      if (re && we)  chk_eq({tag, " bus on re&we"}, rd, Z_SEEN);
      if (we && !re && !f) mdl_write(d, a, sz, wd);
      if (f) exp_faddr[d] = a;
      @(posedge clk); #1;
      re_s[d] = 1'b0; we_s[d] = 1'b0; oe_s[d] = 1'b0;
      @(negedge clk);
      chk_eq({tag, " bus after ready"}, bus_val(d), Z_SEEN);
      chk_eq({tag, " ready after"}, {31'h0, ready_o[d]}, 32'h0);
      chk_eq({tag, " fault_addr"}, faddr_o[d], exp_faddr[d]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b2b_addr [4];
      logic [1:0]  sz;
      int          r;
      int          cyc;
      bit          seen;

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < NBYTES; i++) mdl[d][i] = 8'h00;
         exp_faddr[d] = 32'h0;
         re_s[d] = 1'b0; we_s[d] = 1'b0; as_s[d] = 2'd0; addr_s[d] = 32'h0;
         drv_s[d] = 32'h0; oe_s[d] = 1'b0;
      end

      // Reset held with a read request pending: nothing may respond.
      rst = 1'b0;
      re_s[1] = 1'b1; as_s[1] = 2'd2; addr_s[1] = BASE;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_eq("reset ready", {31'h0, ready_o[1]}, 32'h0);
         chk_eq("reset fault", {31'h0, fault_o[1]}, 32'h0);
         chk_eq("reset bus", bus1, Z_SEEN);
      end
      re_s[1] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_eq("reset fault_addr ws1", faddr_o[1], 32'h0);
      chk_eq("reset fault_addr ws0", faddr_o[0], 32'h0);

      // Directed word and byte-lane traffic on the one-wait-state instance.
      access(1, 1'b0, 1'b1, 2'd2, BASE + 32'd8,  32'hDEAD_BEEF, "wr word");
      access(1, 1'b1, 1'b0, 2'd2, BASE + 32'd8,  32'h0,        "rd word");
      access(1, 1'b0, 1'b1, 2'd0, BASE + 32'd11, 32'hFFFF_FF5A, "wr byte3");
      access(1, 1'b1, 1'b0, 2'd2, BASE + 32'd8,  32'h0,        "rd merged");
      access(1, 1'b1, 1'b0, 2'd1, BASE + 32'd10, 32'h0,        "rd half hi");
      access(1, 1'b1, 1'b0, 2'd0, BASE + 32'd9,  32'h0,        "rd byte1");

      // Faulting accesses; none may disturb RAM.
      access(1, 1'b1, 1'b0, 2'd2, BASE + 32'd2,  32'h0,        "rd word misal");
      access(1, 1'b0, 1'b1, 2'd3, BASE + 32'd8,  32'h1111_1111, "wr asize3");
      access(1, 1'b1, 1'b1, 2'd2, BASE + 32'd8,  32'h2222_2222, "re and we");
      access(1, 1'b0, 1'b1, 2'd1, BASE + 32'd9,  32'h3333_3333, "wr half misal");
      access(1, 1'b0, 1'b1, 2'd2, BASE + 32'(NBYTES), 32'h4444_4444, "wr past top");
      access(1, 1'b1, 1'b0, 2'd0, BASE - 32'd1,  32'h0,        "rd below base");
      access(1, 1'b1, 1'b0, 2'd2, BASE + 32'd8,  32'h0,        "rd after faults");
      access(1, 1'b1, 1'b0, 2'd2, BASE + 32'(NBYTES) - 32'd4, 32'h0, "rd top word");

      // Reset during WAIT of a write: no completion and no commit.
      access(1, 1'b0, 1'b1, 2'd2, BASE + 32'h20, 32'hA5A5_0F0F, "wr pre-reset");
      @(posedge clk); #1;
      we_s[1] = 1'b1; as_s[1] = 2'd2; addr_s[1] = BASE + 32'h20; drv_s[1] = 32'h1234_5678;
      oe_s[1] = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk_eq("midreset ready", {31'h0, ready_o[1]}, 32'h0);
      @(posedge clk); #1;
      we_s[1] = 1'b0; oe_s[1] = 1'b0;
      @(negedge clk);
      chk_eq("midreset ready2", {31'h0, ready_o[1]}, 32'h0);
      chk_eq("midreset bus", bus1, Z_SEEN);
      rst = 1'b1;
      exp_faddr[0] = 32'h0;
      exp_faddr[1] = 32'h0;
      access(1, 1'b1, 1'b0, 2'd2, BASE + 32'h20, 32'h0, "rd after midreset");

      // Reset during a read completion releases the bus at once.
      access(0, 1'b0, 1'b1, 2'd2, BASE + 32'h30, 32'h0BAD_F00D, "ws0 wr");
      @(posedge clk); #1;
      re_s[0] = 1'b1; as_s[0] = 2'd2; addr_s[0] = BASE + 32'h30;
      @(posedge clk); #1;
      re_s[0] = 1'b0;
      @(negedge clk);
      chk_eq("done drive", bus0, 32'h0BAD_F00D);
      #1 rst = 1'b0;
      #1 chk_eq("done reset release", bus0, Z_SEEN);
      @(negedge clk);
      rst = 1'b1;

      // Zero-wait back-to-back reads: one ready every two cycles.
      for (int k = 0; k < 4; k++) begin
         b2b_addr[k] = BASE + 32'h40 + 32'(4 * k);
         access(0, 1'b0, 1'b1, 2'd2, b2b_addr[k], $urandom, "b2b fill");
      end
      @(posedge clk); #1;
      re_s[0] = 1'b1; as_s[0] = 2'd2; addr_s[0] = b2b_addr[0];
      for (int k = 0; k < 4; k++) begin
         cyc  = 0;
         seen = 1'b0;
         while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ready_o[0] === 1'b1) seen = 1'b1;
         end
         chk_eq("b2b spacing", 32'(cyc), 32'd2);
         chk_eq("b2b data", bus0, mdl_read(0, b2b_addr[k], 2'd2));
         @(posedge clk); #1;
         if (k < 3) addr_s[0] = b2b_addr[k + 1];
         else       re_s[0] = 1'b0;
      end

      // Random mix of sizes, addresses and directions on both instances.
      for (int it = 0; it < 160; it++) begin
         r  = int'($urandom_range(0, 9));
         sz = (r == 9) ? 2'd3 : 2'(r % 3);
         case ($urandom_range(0, 9))
            0:       a = BASE + 32'(NBYTES) + $urandom_range(0, 15);
            1:       a = BASE - 32'd1 - $urandom_range(0, 15);
            2, 3:    a = BASE + 32'(NBYTES) - 32'd32 + $urandom_range(0, 31);
            default: a = BASE + $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         r = int'($urandom_range(0, 19));
         access(int'($urandom_range(0, 1)), (r < 9) || (r == 19), (r >= 9), sz, a, $urandom,
                "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_axo_mem_responder
`default_nettype wire
